// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Multi-port integer register file with NREAD combinational read ports,
//   two byte-masked write ports and a per-register pending-load scoreboard.
//   W0 carries execute results and W1 carries load returns. Register 0 is
//   hard-wired to zero and is never busy.
//
// Ports
//   clk      : system clock, all state updates on the rising edge
//   rst_     : synchronous active-low reset
//   r_addr   : read addresses, port k at [k*AW +: AW]
//   r_data   : read data, port k at [k*BITS +: BITS]
//   r_busy   : per read port, 1 when the addressed register awaits a load
//   w0_*     : execute write port (active-low strobe, address, data, bytes)
//   w1_*     : load-return write port (same layout as W0)
//   sb_set   : mark sb_addr busy because a load has been issued
//   sb_addr  : scoreboard set address
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int WORDS  = 32,
  parameter int BITS   = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(WORDS),
  parameter int BE     = BITS / 8
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [NREAD*AW-1:0]   r_addr,
  output logic [NREAD*BITS-1:0] r_data,
  output logic [NREAD-1:0]      r_busy,
  input  logic                  w0_en_,
  input  logic [AW-1:0]         w0_addr,
  input  logic [BITS-1:0]       w0_data,
  input  logic [BE-1:0]         w0_be,
  input  logic                  w1_en_,
  input  logic [AW-1:0]         w1_addr,
  input  logic [BITS-1:0]       w1_data,
  input  logic [BE-1:0]         w1_be,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_addr
);

  logic [BITS-1:0]  mem_q [WORDS];
  logic [BITS-1:0]  mem_d [WORDS];
  logic [WORDS-1:0] busy_q;
  logic [WORDS-1:0] busy_d;

  // Next-state for the storage array. Each byte is handled on its own so
  // that W0 only overrides W1 on the bytes both ports enable. Data inputs
  // are only consulted under their port's enable, so junk on an idle port
  // cannot reach state. Register 0 is forced back to zero.
  always_comb begin
    for (int n = 0; n < WORDS; n++) begin
      mem_d[n] = mem_q[n];
      for (int b = 0; b < BE; b++) begin
        if (!w0_en_ && (w0_addr == AW'(n)) && w0_be[b]) begin
          mem_d[n][b*8 +: 8] = w0_data[b*8 +: 8];
        end else if (!w1_en_ && (w1_addr == AW'(n)) && w1_be[b]) begin
          mem_d[n][b*8 +: 8] = w1_data[b*8 +: 8];
        end
      end
    end
    mem_d[0] = '0;
  end

  // Next-state for the scoreboard. A load return that actually writes
  // something clears the bit; a new load issue sets it. The set is applied
  // last so a same-cycle issue to the returning register stays outstanding.
  always_comb begin
    busy_d = busy_q;
    for (int n = 1; n < WORDS; n++) begin
      if (!w1_en_ && (w1_addr == AW'(n)) && (w1_be != '0)) begin
        busy_d[n] = 1'b0;
      end
      if (sb_set && (sb_addr == AW'(n))) begin
        busy_d[n] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset that clears every word and
  // every busy bit, ignoring all other inputs on that edge.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      for (int n = 0; n < WORDS; n++) begin
        mem_q[n] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int n = 0; n < WORDS; n++) begin
        mem_q[n] <= mem_d[n];
      end
      busy_q <= busy_d;
    end
  end

  // Read ports. With bypass enabled a same-cycle write to the read address
  // is merged per byte, W0 taking priority over W1 over the stored value.
  // Busy is reported from registered state only.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   rd_addr;
    logic [BITS-1:0] rd_word;

    assign rd_addr = r_addr[k*AW +: AW];

    always_comb begin
      rd_word = mem_q[rd_addr];
      if (BYPASS != 0) begin
        for (int b = 0; b < BE; b++) begin
          if (!w0_en_ && (w0_addr == rd_addr) && w0_be[b]) begin
            rd_word[b*8 +: 8] = w0_data[b*8 +: 8];
          end else if (!w1_en_ && (w1_addr == rd_addr) && w1_be[b]) begin
            rd_word[b*8 +: 8] = w1_data[b*8 +: 8];
          end
        end
      end
      if (rd_addr == '0) begin
        rd_word = '0;
      end
    end

    assign r_data[k*BITS +: BITS] = rd_word;
    assign r_busy[k] = (rd_addr != '0) && busy_q[rd_addr];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//   Self-checking bench for regfile_mp. Two instances share every input:
//   dut_bp has bypass enabled, dut_nb has it disabled, so same-cycle read
//   behaviour of both flavours can be compared against hand-computed values.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int AW = 5;

  logic        clk;
  logic        rst_;
  logic [9:0]  r_addr;
  logic [63:0] r_data_bp;
  logic [63:0] r_data_nb;
  logic [1:0]  r_busy_bp;
  logic [1:0]  r_busy_nb;
  logic        w0_en_;
  logic [4:0]  w0_addr;
  logic [31:0] w0_data;
  logic [3:0]  w0_be;
  logic        w1_en_;
  logic [4:0]  w1_addr;
  logic [31:0] w1_data;
  logic [3:0]  w1_be;
  logic        sb_set;
  logic [4:0]  sb_addr;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic        w0_on;
    logic [4:0]  w0_a;
    logic [31:0] w0_d;
    logic [3:0]  w0_b;
    logic        w1_on;
    logic [4:0]  w1_a;
    logic [31:0] w1_d;
    logic [3:0]  w1_b;
    logic        sb_on;
    logic [4:0]  sb_a;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [1:0]  exp_busy;
  } vec_t;

  vec_t vecs [14];

  regfile_mp #(.BYPASS(1)) dut_bp (
    .clk(clk), .rst_(rst_),
    .r_addr(r_addr), .r_data(r_data_bp), .r_busy(r_busy_bp),
    .w0_en_(w0_en_), .w0_addr(w0_addr), .w0_data(w0_data), .w0_be(w0_be),
    .w1_en_(w1_en_), .w1_addr(w1_addr), .w1_data(w1_data), .w1_be(w1_be),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_(rst_),
    .r_addr(r_addr), .r_data(r_data_nb), .r_busy(r_busy_nb),
    .w0_en_(w0_en_), .w0_addr(w0_addr), .w0_data(w0_data), .w0_be(w0_be),
    .w1_en_(w1_en_), .w1_addr(w1_addr), .w1_data(w1_data), .w1_be(w1_be),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Return all write/scoreboard strobes to idle.
  task automatic idleInputs();
    w0_en_ = 1'b1; w0_addr = '0; w0_data = '0; w0_be = '0;
    w1_en_ = 1'b1; w1_addr = '0; w1_data = '0; w1_be = '0;
    sb_set = 1'b0; sb_addr = '0;
  endtask

  // Advance one rising edge and settle a little after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one table vector for a single cycle, then read back stored state
  // with the ports idle so both instances must agree with the expectation.
  task automatic applyStimulus(input vec_t v, input int idx);
    w0_en_ = ~v.w0_on; w0_addr = v.w0_a; w0_data = v.w0_d; w0_be = v.w0_b;
    w1_en_ = ~v.w1_on; w1_addr = v.w1_a; w1_data = v.w1_d; w1_be = v.w1_b;
    sb_set = v.sb_on;  sb_addr = v.sb_a;
    r_addr = {v.ra1, v.ra0};
    tick();
    idleInputs();
    #1;
    checkOutput($sformatf("vec%0d bp rd0", idx), r_data_bp[31:0],  v.exp0);
    checkOutput($sformatf("vec%0d bp rd1", idx), r_data_bp[63:32], v.exp1);
    checkOutput($sformatf("vec%0d nb rd0", idx), r_data_nb[31:0],  v.exp0);
    checkOutput($sformatf("vec%0d nb rd1", idx), r_data_nb[63:32], v.exp1);
    checkOutput($sformatf("vec%0d bp busy", idx), {30'd0, r_busy_bp}, {30'd0, v.exp_busy});
    checkOutput($sformatf("vec%0d nb busy", idx), {30'd0, r_busy_nb}, {30'd0, v.exp_busy});
  endtask

  // Main sequence: reset, reset-after-fill, table vectors, bypass corners.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_   = 1'b0;
    r_addr = '0;
    idleInputs();

    // Each entry: w0{on,a,d,be} w1{on,a,d,be} sb{on,a} reads{a0,a1} expected{d0,d1,busy}
    vecs[0]  = '{1, 5, 32'h11223344, 4'hF, 0, 0, 32'h0,        4'h0, 0, 0, 5, 0, 32'h11223344, 32'h0,        2'b00};
    vecs[1]  = '{1, 5, 32'hAABBCCDD, 4'h5, 0, 0, 32'h0,        4'h0, 0, 0, 5, 0, 32'h11BB33DD, 32'h0,        2'b00};
    vecs[2]  = '{1, 5, 32'hFFFFFFFF, 4'h0, 0, 0, 32'h0,        4'h0, 0, 0, 5, 0, 32'h11BB33DD, 32'h0,        2'b00};
    vecs[3]  = '{1, 7, 32'h000000AA, 4'h1, 1, 7, 32'hBBBBBBBB, 4'hF, 0, 0, 7, 5, 32'hBBBBBBAA, 32'h11BB33DD, 2'b00};
    vecs[4]  = '{0, 0, 32'h0,        4'h0, 1, 6, 32'h12345678, 4'hC, 0, 0, 6, 0, 32'h12340000, 32'h0,        2'b00};
    vecs[5]  = '{1, 6, 32'h0000ABCD, 4'h3, 1, 6, 32'h00EEEE00, 4'h6, 0, 0, 6, 7, 32'h12EEABCD, 32'hBBBBBBAA, 2'b00};
    vecs[6]  = '{0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 1, 9, 9, 5, 32'h0,        32'h11BB33DD, 2'b01};
    vecs[7]  = '{1, 9, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0,        4'h0, 0, 0, 9, 0, 32'hDEADBEEF, 32'h0,        2'b01};
    vecs[8]  = '{0, 0, 32'h0,        4'h0, 1, 9, 32'h01020304, 4'hF, 0, 0, 9, 0, 32'h01020304, 32'h0,        2'b00};
    vecs[9]  = '{0, 0, 32'h0,        4'h0, 1, 9, 32'h55555555, 4'hF, 1, 9, 9, 0, 32'h55555555, 32'h0,        2'b01};
    vecs[10] = '{0, 0, 32'h0,        4'h0, 1, 9, 32'h99999999, 4'h0, 0, 0, 9, 0, 32'h55555555, 32'h0,        2'b01};
    vecs[11] = '{0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 1, 9, 9, 0, 32'h55555555, 32'h0,        2'b01};
    vecs[12] = '{1, 0, 32'h12345678, 4'hF, 1, 0, 32'h87654321, 4'hF, 1, 0, 0, 9, 32'h0,        32'h55555555, 2'b10};
    vecs[13] = '{0, 0, 32'h0,        4'h0, 1, 9, 32'h000000AA, 4'h1, 0, 0, 9, 0, 32'h555555AA, 32'h0,        2'b00};

    // Power-on reset: everything reads zero.
    repeat (2) @(posedge clk);
    #1;
    rst_ = 1'b1;
    r_addr = {5'd31, 5'd1};
    #1;
    checkOutput("por rd0", r_data_bp[31:0], 32'h0);
    checkOutput("por rd1", r_data_bp[63:32], 32'h0);

    // Fill r1..r31 with all ones and mark them busy.
    for (int n = 1; n < 32; n++) begin
      w0_en_ = 1'b0; w0_addr = 5'(n); w0_data = 32'hFFFFFFFF; w0_be = 4'hF;
      sb_set = 1'b1; sb_addr = 5'(n);
      tick();
    end
    idleInputs();
    r_addr = {5'd31, 5'd17};
    #1;
    checkOutput("fill r17", r_data_nb[31:0], 32'hFFFFFFFF);
    checkOutput("fill busy", {30'd0, r_busy_nb}, 32'h3);

    // One reset cycle with a write and a load issue being driven; both ignored.
    rst_ = 1'b0;
    w0_en_ = 1'b0; w0_addr = 5'd3; w0_data = 32'h12345678; w0_be = 4'hF;
    sb_set = 1'b1; sb_addr = 5'd4;
    tick();
    rst_ = 1'b1;
    idleInputs();
    for (int n = 0; n < 32; n += 2) begin
      r_addr = {5'(n + 1), 5'(n)};
      #1;
      checkOutput($sformatf("rst data r%0d", n), r_data_nb[31:0], 32'h0);
      checkOutput($sformatf("rst data r%0d", n + 1), r_data_nb[63:32], 32'h0);
      checkOutput($sformatf("rst busy r%0d/r%0d", n, n + 1), {30'd0, r_busy_nb}, 32'h0);
    end

    // Table-driven vectors.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Bypass: same-cycle W0 to r3 is visible only on the bypassing instance.
    w0_en_ = 1'b0; w0_addr = 5'd3; w0_data = 32'hCAFE0001; w0_be = 4'hF;
    r_addr = {5'd0, 5'd3};
    #1;
    checkOutput("byp bp same", r_data_bp[31:0], 32'hCAFE0001);
    checkOutput("byp nb same", r_data_nb[31:0], 32'h0);
    tick();
    idleInputs();
    #1;
    checkOutput("byp nb next", r_data_nb[31:0], 32'hCAFE0001);

    // Bypass merge: W0 byte0, W1 bytes0-1, stored upper half.
    w0_en_ = 1'b0; w0_addr = 5'd3; w0_data = 32'h000000EE; w0_be = 4'h1;
    w1_en_ = 1'b0; w1_addr = 5'd3; w1_data = 32'h0000DDDD; w1_be = 4'h3;
    #1;
    checkOutput("merge bp", r_data_bp[31:0], 32'hCAFEDDEE);
    checkOutput("merge nb", r_data_nb[31:0], 32'hCAFE0001);
    tick();
    idleInputs();
    #1;
    checkOutput("merge stored", r_data_nb[31:0], 32'hCAFEDDEE);

    // Bypass never applies to r0, and busy never bypasses a set.
    w0_en_ = 1'b0; w0_addr = 5'd0; w0_data = 32'hFFFFFFFF; w0_be = 4'hF;
    sb_set = 1'b1; sb_addr = 5'd4;
    r_addr = {5'd4, 5'd0};
    #1;
    checkOutput("byp r0", r_data_bp[31:0], 32'h0);
    checkOutput("busy no byp", {30'd0, r_busy_bp}, 32'h0);
    tick();
    idleInputs();
    #1;
    checkOutput("busy r4 next", {30'd0, r_busy_bp}, 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
